// File: rtl/batpu_pkg.sv
// Shared register-file widths and the writeback request record used by both
// writeback sources and the load queue.
package batpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests. No fall-through: a push is
// visible at the head only from the following cycle.
module wb_fifo import batpu_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data and needs no reset; occupancy lives in count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and queued load writebacks onto the register file's single write
// port, with anti-starvation for loads and a pending-load hazard scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W       = batpu_pkg::DATA_W,
  parameter int ADDR_W       = batpu_pkg::ADDR_W,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_rd,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  input  logic [ADDR_W-1:0] chk_rd,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_din
);
  import batpu_pkg::*;

  localparam int NREG = 1 << ADDR_W;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = $clog2(LQ_DEPTH) + 1;

  logic [SW-1:0]   starve_q, starve_d;
  logic [NREG-1:0] pending_q, pending_d;

  wb_req_t         ld_req, lq_head;
  logic            lq_full, lq_empty, lq_push, lq_pop;
  logic [CW-1:0]   lq_count;
  logic            force_ld, alu_win, ld_grant;

  always_comb begin
    ld_req.rd   = ld_rd;
    ld_req.data = ld_data;
  end

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .pop   (lq_pop),
    .din   (ld_req),
    .dout  (lq_head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  // Grant: a starved load beats the ALU; r0 ALU writes never claim the port.
  always_comb begin
    force_ld   = (starve_q == SW'(STARVE_LIMIT)) && !lq_empty;
    alu_win    = !force_ld && alu_valid && (alu_rd != '0);
    ld_grant   = !lq_empty && !alu_win;
    alu_ready  = !force_ld;
    ld_ready   = !lq_full;
    lq_push    = clk_en && !rst && ld_valid && !lq_full && (ld_rd != '0);
    lq_pop     = clk_en && !rst && ld_grant;
    rf_we      = clk_en && !rst && (alu_win || ld_grant);
    rf_rd_addr = ld_grant ? lq_head.rd   : alu_rd;
    rf_din     = ld_grant ? lq_head.data : alu_data;
  end

  always_comb begin
    starve_d = starve_q;
    if (clk_en) begin
      if (ld_grant || (lq_count == '0)) starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end
  end

  // Set is applied after clear so a same-cycle reissue to the register wins.
  always_comb begin
    pending_d = pending_q;
    if (clk_en) begin
      if (lq_pop) pending_d[lq_head.rd] = 1'b0;
      if (sb_set) pending_d[sb_rd]      = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign stall = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares every asserted rf_we.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst, clk_en;
  logic       alu_valid, alu_ready, ld_valid, ld_ready, sb_set, stall, rf_we;
  logic [3:0] alu_rd, ld_rd, sb_rd, chk_rs1, chk_rs2, chk_rd, rf_rd_addr;
  logic [7:0] alu_data, ld_data, rf_din;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  regfile_wb_arbiter #(
    .DATA_W(8), .ADDR_W(4), .LQ_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .sb_set     (sb_set),
    .sb_rd      (sb_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_din     (rf_din)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; clk_en = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    sb_set = 1'b0; sb_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write unexpected addr=%0d data=%0h", rf_rd_addr, rf_din);
      end else begin
        e = exp_q.pop_front();
        if (rf_rd_addr !== e.addr || rf_din !== e.data) begin
          errors++;
          $display("FAIL rf_write got addr=%0d data=%0h expected addr=%0d data=%0h",
                   rf_rd_addr, rf_din, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    // Reset values
    idle(); rst = 1'b1; tick(); tick();
    rst = 1'b0; chk_rs1 = 4'd3; chk_rs2 = 4'd6; chk_rd = 4'd9; #1;
    chk("rst_rf_we", rf_we, 0); chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1); chk("rst_stall", stall, 0);
    tick();

    // Single load, written one cycle after acceptance
    idle(); ld_valid = 1; ld_rd = 4'd3; ld_data = 8'h5A; #1;
    chk("s1_ld_ready", ld_ready, 1); chk("s1_no_fallthru", rf_we, 0); tick();
    idle(); expw(4'd3, 8'h5A); #1; chk("s1_ld_we", rf_we, 1); tick();
    idle(); #1; chk("s1_idle_we", rf_we, 0); tick();

    // Starvation: ALU every cycle, one queued load forced after 4 losses
    idle(); alu_valid = 1; alu_rd = 4'd1; alu_data = 8'h10;
    ld_valid = 1; ld_rd = 4'd2; ld_data = 8'h22; expw(4'd1, 8'h10); #1;
    chk("s2_alu_ready0", alu_ready, 1); tick();
    ld_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      alu_data = 8'(8'h10 + i); expw(4'd1, 8'(8'h10 + i)); #1;
      chk("s2_alu_ready", alu_ready, 1); tick();
    end
    alu_data = 8'h15; expw(4'd2, 8'h22); #1;
    chk("s2_force_alu_ready", alu_ready, 0); chk("s2_force_we", rf_we, 1); tick();
    expw(4'd1, 8'h15); #1; chk("s2_resume", alu_ready, 1); tick();

    // Fill the queue while the ALU holds the port, then drain in order
    idle(); alu_valid = 1; alu_rd = 4'd1; alu_data = 8'h30;
    ld_valid = 1; ld_rd = 4'd4; ld_data = 8'h44; expw(4'd1, 8'h30); #1;
    chk("s3_ready_empty", ld_ready, 1); tick();
    alu_data = 8'h31; ld_rd = 4'd5; ld_data = 8'h55; expw(4'd1, 8'h31); #1;
    chk("s3_ready_one", ld_ready, 1); tick();
    alu_data = 8'h32; ld_rd = 4'd7; ld_data = 8'h77; expw(4'd1, 8'h32); #1;
    chk("s3_full", ld_ready, 0); tick();
    alu_valid = 0; expw(4'd4, 8'h44); #1;
    chk("s3_full_during_pop", ld_ready, 0); tick();
    ld_valid = 0; expw(4'd5, 8'h55); #1; chk("s3_ready_after_pop", ld_ready, 1); tick();
    idle(); #1; chk("s3_drained", rf_we, 0); tick();

    // Scoreboard hazards
    idle(); sb_set = 1; sb_rd = 4'd6; chk_rs2 = 4'd6; #1;
    chk("s4_stall_pre", stall, 0); tick();
    sb_set = 0; ld_valid = 1; ld_rd = 4'd6; ld_data = 8'h66;
    alu_valid = 1; alu_rd = 4'd1; alu_data = 8'h40; expw(4'd1, 8'h40); #1;
    chk("s4_stall_rs2", stall, 1); tick();
    ld_valid = 0; alu_valid = 0; expw(4'd6, 8'h66); #1;
    chk("s4_stall_during_clear", stall, 1); tick();
    sb_set = 1; sb_rd = 4'd6; ld_valid = 1; ld_rd = 4'd6; ld_data = 8'h67; #1;
    chk("s4_stall_cleared", stall, 0); tick();
    ld_valid = 0; expw(4'd6, 8'h67); #1; chk("s4_stall_set2", stall, 1); tick();
    sb_set = 0; chk_rs2 = 0; chk_rs1 = 4'd6; ld_valid = 1; ld_rd = 4'd6; ld_data = 8'h68; #1;
    chk("s4_set_wins_rs1", stall, 1); tick();
    ld_valid = 0; chk_rs1 = 0; chk_rd = 4'd6; expw(4'd6, 8'h68); #1;
    chk("s4_stall_rd", stall, 1); tick();
    #1; chk("s4_final_clear", stall, 0); tick();

    // r0 writes are accepted and dropped
    idle(); alu_valid = 1; alu_rd = 4'd0; alu_data = 8'hEE;
    ld_valid = 1; ld_rd = 4'd0; ld_data = 8'hDD; sb_set = 1; sb_rd = 4'd0; #1;
    chk("s5_alu_ready", alu_ready, 1); chk("s5_ld_ready", ld_ready, 1);
    chk("s5_alu_r0_we", rf_we, 0); tick();
    idle(); #1; chk("s5_discarded", rf_we, 0); chk("s5_r0_pending", stall, 0); tick();

    // clk_en pause with traffic pending
    idle(); ld_valid = 1; ld_rd = 4'd8; ld_data = 8'h88;
    alu_valid = 1; alu_rd = 4'd1; alu_data = 8'h50; sb_set = 1; sb_rd = 4'd9;
    expw(4'd1, 8'h50); #1; tick();
    ld_valid = 0; sb_set = 0; alu_data = 8'h51; expw(4'd1, 8'h51); #1; tick();
    clk_en = 0; alu_data = 8'h52; ld_valid = 1; ld_rd = 4'd10; ld_data = 8'hAA;
    sb_set = 1; sb_rd = 4'd11; chk_rs1 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1; chk("s6_pause_we", rf_we, 0); chk("s6_pause_stall", stall, 1);
      chk("s6_pause_alu_ready", alu_ready, 1); tick();
    end
    clk_en = 1; ld_valid = 0; sb_set = 0; chk_rs1 = 0; chk_rd = 4'd11;
    expw(4'd1, 8'h52); #1; chk("s6_no_sb_in_pause", stall, 0); tick();
    alu_data = 8'h53; expw(4'd1, 8'h53); #1; chk("s6_alu_53", alu_ready, 1); tick();
    alu_data = 8'h54; expw(4'd1, 8'h54); #1; chk("s6_alu_54", alu_ready, 1); tick();
    alu_data = 8'h55; expw(4'd8, 8'h88); #1; chk("s6_force", alu_ready, 0); tick();
    alu_valid = 0; chk_rd = 0; chk_rs1 = 4'd9; #1;
    chk("s6_no_ld_in_pause", rf_we, 0); chk("s6_pend9", stall, 1); tick();

    // Reset mid-burst flushes the queue and the scoreboard
    idle(); ld_valid = 1; ld_rd = 4'd12; ld_data = 8'hC2;
    alu_valid = 1; alu_rd = 4'd1; alu_data = 8'h60; sb_set = 1; sb_rd = 4'd13;
    expw(4'd1, 8'h60); #1; tick();
    ld_rd = 4'd14; ld_data = 8'hE4; alu_data = 8'h61; sb_set = 0; rst = 1; #1;
    chk("s7_rst_we", rf_we, 0); tick();
    rst = 0; alu_valid = 0; ld_valid = 0; chk_rs1 = 4'd9; chk_rs2 = 4'd13; chk_rd = 4'd12; #1;
    chk("s7_flushed_we", rf_we, 0); chk("s7_pending_clear", stall, 0);
    chk("s7_ld_ready", ld_ready, 1); chk("s7_alu_ready", alu_ready, 1); tick();
    idle(); #1; chk("s7_still_idle", rf_we, 0); tick();

    chk("scoreboard_drained", 8'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 16×8 register file's single write port. It merges the ALU writeback (zero-latency, normally highest priority) and the load-unit writeback (buffered in a small FIFO) onto the `rf_we`/`rf_rd_addr`/`rf_din` port. It tracks registers with outstanding loads so decode can stall on RAW/WAW hazards, and guarantees loads are not starved. It sits between execute/memory and the register file.

## Interface
Parameters:
- `DATA_W`, 8, register width
- `ADDR_W`, 4, register address width (16 registers, r0 hard-zero)
- `LQ_DEPTH`, 2, load writeback FIFO depth (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive enabled cycles a non-empty load queue may lose before it is forced

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `clk_en` in 1: global clock enable. State only advances when it is 1.
- `alu_valid` in 1: ALU writeback request.
- `alu_ready` out 1: ALU write accepted this cycle.
- `alu_rd` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU write data.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: load queue can accept.
- `ld_rd` in ADDR_W: load destination register.
- `ld_data` in DATA_W: load data.
- `sb_set` in 1: a load issued this cycle; mark `sb_rd` pending.
- `sb_rd` in ADDR_W: destination register of the issued load.
- `chk_rs1`, `chk_rs2`, `chk_rd` in ADDR_W: register addresses of the instruction in decode.
- `stall` out 1: decode must hold.
- `rf_we` out 1: register-file write enable.
- `rf_rd_addr` out ADDR_W: register-file write address.
- `rf_din` out DATA_W: register-file write data.

## Operation
- A transfer happens only when `clk_en`=1:
  - ALU transfer: `alu_valid & alu_ready`.
  - Load transfer: `ld_valid & ld_ready`.
- `ld_ready` = queue not full. It does not depend on a same-cycle pop.
- A load with `ld_rd`=0 is accepted and discarded; it is not enqueued.
- An ALU write with `alu_rd`=0 is accepted (`alu_ready`=1) but drives `rf_we`=0.
- Grant, evaluated each cycle:
  - Force mode (starve counter = `STARVE_LIMIT` and queue non-empty): the queue head wins and `alu_ready`=0.
  - Otherwise, if `alu_valid` and `alu_rd`≠0: the ALU wins and `alu_ready`=1.
  - Otherwise, a non-empty queue pops its head.
  - Otherwise, nothing is granted and `alu_ready`=1.
- `rf_we` = `grant & clk_en`. The address and data come from the granted source.
- Starve counter:
  - Increments each enabled cycle in which the queue is non-empty and the load loses.
  - Clears on a load grant or when the queue is empty.
  - Saturates at `STARVE_LIMIT`.
- Scoreboard: one pending bit per register. Bit 0 is never set.
  - `sb_set` (enabled) sets `pending[sb_rd]`.
  - A load write granted to rf clears `pending[rf_rd_addr]`.
  - Same-cycle set and clear of the same register: set wins.
  - A discarded r0 load clears nothing.
- `stall` = `pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]`. This is combinational from current state and does not look at same-cycle clears.
- `clk_en`=0: no FIFO, counter or scoreboard change; `rf_we`=0.

## Timing
- Reset values, present in the cycle after `rst` is sampled high:
  - Queue empty, all pending bits 0, starve counter 0.
  - `rf_we`=0, `ld_ready`=1, `alu_ready`=1, `stall`=0.
  - `rst` overrides all same-cycle transfers.
- ALU path: zero latency. A request in cycle N produces `rf_we` in cycle N, and the register file commits at edge N.
- Load path: a load accepted at edge N can be written in cycle N+1 at the earliest.
- The FIFO is strict in-order. Pointers wrap modulo `LQ_DEPTH`. A push to a full queue is impossible by handshake.
- Simultaneous push and pop on a non-empty queue: occupancy is unchanged.
- A push to an empty queue cannot pop in the same cycle; there is no fall-through.
- Maximum ALU denial: 1 cycle per `STARVE_LIMIT`+1 cycles of contention.

## Structure
- Package `batpu_pkg` holds:
  - `DATA_W` and `ADDR_W` constants.
  - `reg_addr_t` and `reg_data_t` typedefs.
  - Packed struct `wb_req_t` {rd, data}, shared by both writeback sources and the FIFO.
- Sub-module `wb_fifo`: synchronous `wb_req_t` FIFO with push/pop/full/empty/count. The arbiter, counter and scoreboard stay in the top module.

## Test plan
- Reset → all outputs at their reset values. Then `ld_valid` with rd=3, data=0x5A, no ALU traffic → `rf_we` one cycle later with addr 3, data 0x5A.
- ALU every cycle (rd=1) plus one queued load (rd=2) → ALU granted for 4 cycles, then the load is forced with `alu_ready`=0 for one cycle, then the ALU resumes.
- Fill the queue with loads to rd 4 and 5 while the ALU holds the port → `ld_ready`=0 until the first pop. Writes reach rf in order 4, then 5.
- `sb_set` rd=6, then `chk_rs2`=6 → `stall`=1 until the cycle after the load to r6 is written. `sb_set` rd=6 in the same cycle as that write → pending stays 1.
- ALU write rd=0 and load rd=0 → both accepted, `rf_we` never asserted, scoreboard unchanged.
- `clk_en`=0 for 3 cycles with traffic pending → no state change and `rf_we`=0. After re-enabling, traffic proceeds exactly as if the pause had not happened. `rst` mid-burst → queue flushed and pending bits cleared.
